nibble_link_ctrl: RTL and testbench
===================================

# nibble_link_ctrl

Controller that sequences the 4-bit nibble source on the serial link. It requests a nibble with a one-cycle `ask_for_data` pulse and latches the nibble two cycles later. It then transmits the nibble MSB-first on a two-wire `scl`/`sda` link, framed by start and stop conditions. The block sits between the nibble source (driven by `sclk`/`rst`) and the serial receiver, and is the only driver of `ask_for_data`.

## Interface
- `NBITS`, 4: nibble width; fixed at 4 in this revision.
- `GAP`, 1: idle `sclk` cycles between the stop condition and the next request (0 allowed).

- `sclk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `en`  input  1  run enable; sampled only in IDLE and at the end of GAP.
- `data`  input  4  nibble from the source; valid from 2 cycles after the `ask_for_data` rise.
- `ask_for_data`  output  1  one-cycle request pulse to the source.
- `scl`  output  1  serial clock; idle high.
- `sda`  output  1  serial data; idle high.
- `busy`  output  1  high from REQ through STOP.
- `frame_done`  output  1  one-cycle pulse in the STOP cycle.

## Operation
- All outputs are registered. Each output shows its state's value during the cycle that state is occupied.
- Reset values: `ask_for_data`=0, `scl`=1, `sda`=1, `busy`=0, `frame_done`=0, state=IDLE, shift register=0, bit counter=0.
- State sequence and outputs (scl/sda/ask):
  - IDLE: 1/1/0. If `en`=1, go to REQ; otherwise stay.
  - REQ: 1/1/1. Request pulse to the source.
  - WAIT: 1/1/0. Source updates `data` during this cycle.
  - LOAD: 1/1/0. Shift register is loaded from `data` on the rising edge that leaves LOAD.
  - START: 1/0/0. `sda` falls while `scl` is high.
  - BLO: 0/shreg[3]/0. `sda` changes only while `scl` is low.
  - BHI: 1/held/0. Shift left by 1; bit counter increments. If the counter wraps 3→0, go to PLO; otherwise go to BLO.
  - PLO: 0/0/0.
  - PHI: 1/0/0.
  - STOP: 1/1/0. `sda` rises while `scl` is high; `frame_done`=1.
  - GAP: 1/1/0 for `GAP` cycles. At the end, go to REQ if `en`=1, else IDLE. With `GAP`=0, STOP goes directly to REQ or IDLE.
- Deasserting `en` mid-frame has no effect. The current frame completes and the controller then parks in IDLE.
- Reset asserted mid-frame: outputs return to their reset values immediately (asynchronously). Any partial frame is abandoned, and no stop condition is generated.
- Invariant: `sda` never changes while `scl` is high, except at START (falling) and STOP (rising).

## Timing
- Let R be the cycle in which REQ is entered.
  - First REQ: R = 1 cycle after the first `sclk` edge at which `rst`=1 and `en`=1.
  - R: `ask_for_data`=1.
  - R+2: LOAD; `data` is sampled at the end of R+2. The source responds within half a cycle, so this leaves more than 1 cycle of margin.
  - R+3: START.
  - R+4..R+11: bits 3,2,1,0, each as BLO then BHI.
  - R+12: PLO.
  - R+13: PHI.
  - R+14: STOP.
- Frame period with `en` held high: 15+`GAP` cycles (16 by default).
- Request-to-first-bit latency: 4 cycles.

## Structure
- Shared package contents:
  - state encoding constants (11 states, 4-bit encoding);
  - `NBITS`;
  - idle line levels (`scl`/`sda` = 1).
- Single module with no sub-module. It contains:
  - state register;
  - 2-bit bit counter;
  - 4-bit shift register;
  - GAP counter, width clog2(`GAP`+1), minimum 1 bit.

## Test plan
- Reset release with `en`=1; source starts at 0 and increments on each request:
  - first frame sends 0001 (`sda` sampled on `scl` rises in R+5,7,9,11 = 0,0,0,1);
  - second frame sends 0010;
  - `ask_for_data` pulses exactly once per 16 cycles.
- Continuous run, 20 frames: received nibbles are 1..15, 0, 1..4 (4-bit wrap). No `sda` change while `scl`=1 other than start/stop edges.
- `en` dropped at R+6: frame completes with STOP at R+14. Controller then stays in IDLE with `scl`=`sda`=1 and no further `ask_for_data`.
- `rst` asserted low at R+7, asynchronously mid-cycle:
  - `scl`, `sda`, `busy`, `frame_done`, `ask_for_data` immediately go to 1, 1, 0, 0, 0;
  - after release, the next frame starts from REQ.
- `GAP`=0 build: frame period is 15 cycles and STOP is immediately followed by REQ.
- `data` forced to 1010 at LOAD and changed to 0101 during START: transmitted bits are 1,0,1,0.

Source files
------------

// File: rtl/nibble_link_ctrl_pkg.sv
// Shared definitions for the nibble link controller: state encoding, nibble width,
// idle line levels and the registered output bundle.
package nibble_link_ctrl_pkg;

  localparam int NBITS = 4;

  localparam logic SCL_IDLE = 1'b1;
  localparam logic SDA_IDLE = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_REQ   = 4'd1,
    ST_WAIT  = 4'd2,
    ST_LOAD  = 4'd3,
    ST_START = 4'd4,
    ST_BLO   = 4'd5,
    ST_BHI   = 4'd6,
    ST_PLO   = 4'd7,
    ST_PHI   = 4'd8,
    ST_STOP  = 4'd9,
    ST_GAP   = 4'd10
  } state_e;

  typedef struct packed {
    logic ask;
    logic scl;
    logic sda;
    logic busy;
    logic frame_done;
  } line_out_t;

  localparam line_out_t OUT_RESET = '{
    ask:        1'b0,
    scl:        SCL_IDLE,
    sda:        SDA_IDLE,
    busy:       1'b0,
    frame_done: 1'b0
  };

  // A frame is in progress from the request up to and including the stop condition.
  function automatic logic frame_active(input state_e s);
    return (s != ST_IDLE) && (s != ST_GAP);
  endfunction

endpackage

// File: rtl/nibble_link_ctrl_if.sv
// Bundle of the source handshake and serial line signals around the controller.
interface nibble_link_ctrl_if;
  import nibble_link_ctrl_pkg::*;

  logic             en;
  logic [NBITS-1:0] data;
  logic             ask_for_data;
  logic             scl;
  logic             sda;
  logic             busy;
  logic             frame_done;

  modport master (
    input  en, data,
    output ask_for_data, scl, sda, busy, frame_done
  );

  modport slave (
    output en, data,
    input  ask_for_data, scl, sda, busy, frame_done
  );

endinterface

// File: rtl/nibble_link_ctrl.sv
// Requests a nibble from the source, then sends it MSB-first on scl/sda framed by
// start and stop conditions. Every output is registered from the next-state value.
module nibble_link_ctrl
  import nibble_link_ctrl_pkg::*;
#(
  parameter int GAP = 1
) (
  input  logic              sclk,
  input  logic              rst,
  nibble_link_ctrl_if.master link
);

  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_e           state_q, state_d;
  logic [1:0]       bit_cnt_q, bit_cnt_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  line_out_t        out_q, out_d;

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      gap_cnt_q <= '0;
      out_q     <= OUT_RESET;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      gap_cnt_q <= gap_cnt_d;
      out_q     <= out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE:  if (link.en) state_d = ST_REQ;
      ST_REQ:   state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_LOAD;
      ST_LOAD: begin
        shreg_d = link.data;
        state_d = ST_START;
      end
      ST_START: state_d = ST_BLO;
      ST_BLO:   state_d = ST_BHI;
      ST_BHI: begin
        shreg_d   = {shreg_q[NBITS-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 2'd1;
        state_d   = (bit_cnt_q == 2'd3) ? ST_PLO : ST_BLO;
      end
      ST_PLO:   state_d = ST_PHI;
      ST_PHI:   state_d = ST_STOP;
      ST_STOP: begin
        gap_cnt_d = '0;
        if (GAP == 0) state_d = link.en ? ST_REQ : ST_IDLE;
        else          state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = link.en ? ST_REQ : ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the state about to be entered so the registered
  // values line up with the cycle that state is occupied.
  always_comb begin
    out_d      = OUT_RESET;
    out_d.busy = frame_active(state_d);
    case (state_d)
      ST_REQ:   out_d.ask = 1'b1;
      ST_START: out_d.sda = 1'b0;
      ST_BLO: begin
        out_d.scl = 1'b0;
        out_d.sda = shreg_d[NBITS-1];
      end
      ST_BHI:   out_d.sda = out_q.sda;
      ST_PLO: begin
        out_d.scl = 1'b0;
        out_d.sda = 1'b0;
      end
      ST_PHI:   out_d.sda = 1'b0;
      ST_STOP:  out_d.frame_done = 1'b1;
      default:  ;
    endcase
  end

  assign link.ask_for_data = out_q.ask;
  assign link.scl          = out_q.scl;
  assign link.sda          = out_q.sda;
  assign link.busy         = out_q.busy;
  assign link.frame_done   = out_q.frame_done;

endmodule

// File: tb/tb_nibble_link_ctrl.sv
// Directed-plus-random bench: decodes the serial line into frames and compares
// them with the nibbles the source offered, plus request/stop timing rules.
module tb_nibble_link_ctrl;
  import nibble_link_ctrl_pkg::*;

  logic sclk = 1'b0;
  logic rst  = 1'b1;

  nibble_link_ctrl_if link0 ();
  nibble_link_ctrl_if link1 ();

  nibble_link_ctrl #(.GAP(1)) dut0 (.sclk(sclk), .rst(rst), .link(link0.master));
  nibble_link_ctrl #(.GAP(0)) dut1 (.sclk(sclk), .rst(rst), .link(link1.master));

  always #5 sclk = ~sclk;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  int auto_src = 1;
  // GAP=1 instance model
  int have_r0 = 0, r0 = 0, en_low0 = 1, asks0 = 0;
  logic prev_ask0 = 1'b0;
  int in_frame = 0, nb = 0, frames_rx = 0;
  logic [4:0] bits5 = '0;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  logic [3:0] exp_q[$];
  logic [3:0] rx_hist[$];
  // GAP=0 instance model
  int have_r1 = 0, r1 = 0, en_low1 = 1;
  logic prev_ask1 = 1'b0, prev_fd1 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_scl"},  link0.scl, 1);
    check({tag, "_sda"},  link0.sda, 1);
    check({tag, "_busy"}, link0.busy, 0);
    check({tag, "_fd"},   link0.frame_done, 0);
    check({tag, "_ask"},  link0.ask_for_data, 0);
    check({tag, "_ask1"}, link1.ask_for_data, 0);
  endtask

  task automatic clear_model();
    have_r0 = 0; en_low0 = 1; prev_ask0 = 1'b0;
    in_frame = 0; nb = 0; bits5 = '0;
    prev_scl = 1'b1; prev_sda = 1'b1;
    exp_q.delete();
    have_r1 = 0; en_low1 = 1; prev_ask1 = 1'b0; prev_fd1 = 1'b0;
  endtask

  task automatic tick();
    logic [3:0] e;
    @(posedge sclk);
    #1;
    cyc++;
    // request rules for the GAP=1 instance
    if (link0.ask_for_data === 1'b1) begin
      check("ask0_single_cycle", prev_ask0, 0);
      if (have_r0 && !en_low0) check("ask0_period", cyc - r0, 16);
      r0 = cyc; have_r0 = 1; en_low0 = 0; asks0++;
    end
    prev_ask0 = link0.ask_for_data;
    check("busy0", link0.busy, (have_r0 && (cyc - r0) <= 14) ? 1 : 0);
    check("frame_done0", link0.frame_done, (have_r0 && (cyc - r0) == 14) ? 1 : 0);
    // value the source held through the end of R+2
    if (have_r0 && cyc == r0 + 3) exp_q.push_back(link0.data);
    // line decoder: start, bit clocks, stop
    if (prev_scl && link0.scl && (link0.sda !== prev_sda)) begin
      if (!link0.sda && !in_frame) begin
        in_frame = 1; nb = 0; bits5 = '0;
        check("start_time", cyc - r0, 3);
      end else if (link0.sda && in_frame) begin
        in_frame = 0;
        check("stop_clock_count", nb, 5);
        check("stop_low_bit", bits5[0], 0);
        check("stop_time", cyc - r0, 14);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
        check("nibble", bits5[4:1], e);
        rx_hist.push_back(bits5[4:1]);
        frames_rx++;
      end else begin
        check("sda_stable_while_scl_high", 0, 1);
      end
    end else if (!prev_scl && link0.scl && in_frame) begin
      bits5 = {bits5[3:0], link0.sda};
      nb++;
    end
    prev_scl = link0.scl;
    prev_sda = link0.sda;
    if (!link0.en || !rst) en_low0 = 1;
    if (auto_src && have_r0 && cyc == r0 + 1) link0.data = link0.data + 4'd1;
    // GAP=0 instance: back-to-back frames
    if (link1.ask_for_data === 1'b1) begin
      check("ask1_single_cycle", prev_ask1, 0);
      if (have_r1 && !en_low1) begin
        check("ask1_period", cyc - r1, 15);
        check("ask1_after_stop", prev_fd1, 1);
      end
      r1 = cyc; have_r1 = 1; en_low1 = 0;
    end
    prev_ask1 = link1.ask_for_data;
    check("frame_done1", link1.frame_done, (have_r1 && (cyc - r1) == 14) ? 1 : 0);
    prev_fd1 = link1.frame_done;
    if (!link1.en || !rst) en_low1 = 1;
    if (have_r1 && cyc == r1 + 1) link1.data = link1.data + 4'd1;
  endtask

  task automatic wait_ask(output int r);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (link0.ask_for_data !== 1'b1 && n < 64);
    check("ask_seen_in_budget", link0.ask_for_data, 1);
    r = cyc;
  endtask

  initial begin
    int r, rel, a, f;
    logic [3:0] v;
    link0.en = 1'b0; link0.data = 4'd0;
    link1.en = 1'b0; link1.data = 4'd0;
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("reset");
    tick(); tick();
    check_reset_outputs("reset_held");

    // release with en high; source counts up from 0
    link0.en = 1'b1; link1.en = 1'b1; rst = 1'b1;
    rel = cyc;
    wait_ask(r);
    check("first_req_cycle", r - rel, 1);
    for (int i = 0; i < 400 && frames_rx < 20; i++) tick();
    check("frames_received", frames_rx, 20);
    for (int i = 0; i < 20 && i < rx_hist.size(); i++)
      check("wrap_sequence", rx_hist[i], (i + 1) % 16);

    // en dropped at R+6: frame completes, then park
    wait_ask(r);
    repeat (6) tick();
    link0.en = 1'b0; link1.en = 1'b0;
    a = asks0; f = frames_rx;
    repeat (8) tick();
    check("drop_frame_completed", frames_rx, f + 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i % 10 == 9) begin
        check("parked_scl", link0.scl, 1);
        check("parked_sda", link0.sda, 1);
      end
    end
    check("parked_no_request", asks0, a);

    // data presented at LOAD, changed during START
    auto_src = 0;
    link0.en = 1'b1; link1.en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_ask(r);
      tick(); tick();
      v = (k == 0) ? 4'b1010 : 4'($urandom_range(0, 15));
      link0.data = v;
      tick();
      link0.data = ~v;
      repeat (11) tick();
      check("loaded_nibble", rx_hist[rx_hist.size() - 1], v);
    end

    // asynchronous reset mid-frame
    auto_src = 1;
    wait_ask(r);
    repeat (7) tick();
    #3 rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    clear_model();
    f = frames_rx;
    repeat (3) tick();
    check_reset_outputs("reset_mid");
    rst = 1'b1;
    rel = cyc;
    wait_ask(r);
    check("req_after_reset", r - rel, 1);
    repeat (15) tick();
    check("frame_after_reset", frames_rx, f + 1);
    check("frame_after_reset_nibble", rx_hist[rx_hist.size() - 1], link0.data);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
